// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head word is visible combinationally on rdata.
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rdata   = mem[rd_ptr_reg];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push_en) - CW'(pop_en);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge Clk) begin
    if (push_en) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order requests, tag FIFO, prefetch queue, redirect drain.
// Optional same-cycle response bypass to the decoder when FETCH_BYPASS_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCResult,
  output logic [ADDR_W-1:0] PCNext,
  output logic              PCWrite,
  output logic              MemReqValid,
  output logic [ADDR_W-1:0] MemReqAddr,
  input  logic              MemReqReady,
  input  logic              MemRespValid,
  input  logic [DATA_W-1:0] MemRespData,
  output logic              InstValid,
  output logic [DATA_W-1:0] InstData,
  output logic [ADDR_W-1:0] InstPC,
  input  logic              InstReady,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = ADDR_W + DATA_W;

  fetch_state_t      state_reg, state_next;
  logic [CW-1:0]     outstanding_reg, outstanding_next;
  logic [CW-1:0]     discard_reg, discard_next;
  logic [CW-1:0]     stale_sum;
  logic [ADDR_W-1:0] last_pc_reg;
  logic [DATA_W-1:0] last_data_reg;

  logic [ADDR_W-1:0] tag_head;
  logic              tag_full, tag_empty;
  logic [CW-1:0]     tag_count;
  logic [QW-1:0]     q_head;
  logic              q_full, q_empty;
  logic [CW-1:0]     q_count;

  logic issue_ok, handshake, resp_take, bypass, q_push, q_pop;
  logic unused_status;

  assign MemReqAddr    = PCResult;
  assign unused_status = ^{tag_full, tag_empty, tag_count, q_full};

  always_comb begin
    issue_ok  = !Reset && (state_reg == RUN) && !Redirect &&
                (({1'b0, outstanding_reg} + {1'b0, q_count}) < (CW+1)'(DEPTH));
    handshake = issue_ok && MemReqReady;
    // Anything arriving while stale responses remain, or under a redirect, is dropped.
    resp_take = !Reset && MemRespValid && (discard_reg == '0) && !Redirect;
`ifdef FETCH_BYPASS_EN
    bypass    = resp_take && q_empty && InstReady;
`else
    bypass    = 1'b0;
`endif
    q_push    = resp_take && !bypass;
    q_pop     = !q_empty && InstReady && !Redirect;

    MemReqValid = issue_ok;
    InstValid   = !Reset && (!q_empty || bypass);
    InstData    = last_data_reg;
    InstPC      = last_pc_reg;
    if (bypass) begin
      InstData = MemRespData;
      InstPC   = tag_head;
    end else if (!q_empty) begin
      InstData = q_head[DATA_W-1:0];
      InstPC   = q_head[QW-1:DATA_W];
    end

    PCWrite = 1'b0;
    PCNext  = PCResult;
    if (!Reset) begin
      if (Redirect) begin
        PCWrite = 1'b1;
        PCNext  = RedirectPC;
      end else if (handshake) begin
        PCWrite = 1'b1;
        PCNext  = PCResult + ADDR_W'(1);
      end
    end
  end

  // Everything still in flight after this cycle's (stale) response must be discarded.
  always_comb begin
    stale_sum        = discard_reg + outstanding_reg;
    outstanding_next = outstanding_reg + CW'(handshake) - CW'(resp_take);
    discard_next     = discard_reg;
    state_next       = state_reg;
    if (Redirect) begin
      outstanding_next = '0;
      discard_next     = (MemRespValid && stale_sum != '0) ? stale_sum - CW'(1) : stale_sum;
      state_next       = (discard_next != '0) ? DRAIN : RUN;
    end else begin
      if (MemRespValid && discard_reg != '0) discard_next = discard_reg - CW'(1);
      if (state_reg == DRAIN && discard_next == '0) state_next = RUN;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= RUN;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      last_pc_reg     <= ADDR_W'(RESET_PC);
      last_data_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      if (InstValid) begin
        last_pc_reg   <= InstPC;
        last_data_reg <= InstData;
      end
    end
  end

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (handshake),
    .pop   (resp_take),
    .flush (Redirect),
    .wdata (PCResult),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_inst_queue (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (Redirect),
    .wdata ({tag_head, MemRespData}),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that consumes the program counter value and produces its next-PC and write-enable controls. Issues in-order requests to instruction memory at `PCResult` and tags each with its PC. Buffers returned instruction words in a prefetch queue for the decoder. Honours branch/jump redirects by flushing the queue and discarding stale in-flight responses.

## Interface
- `DEPTH`, 4: prefetch queue depth and maximum in-flight requests; power of two, ≥2
- `ADDR_W`, 16: PC/address width
- `DATA_W`, 16: instruction word width
- `Clk` in 1: clock; all state updates on rising edge
- `Reset` in 1: reset Reset, synchronous, active-high; clock Clk
- `PCResult` in ADDR_W: current PC from the program counter register
- `PCNext` out ADDR_W: next PC value to the program counter
- `PCWrite` out 1: program counter load enable
- `MemReqValid` out 1: memory request valid
- `MemReqAddr` out ADDR_W: request address; always equals `PCResult`
- `MemReqReady` in 1: memory accepts the request
- `MemRespValid` in 1: response valid; responses return in request order, latency ≥1, no backpressure
- `MemRespData` in DATA_W: instruction word
- `InstValid` out 1: queue head valid to the decoder
- `InstData` out DATA_W: instruction word at the queue head
- `InstPC` out ADDR_W: PC of the instruction at the queue head
- `InstReady` in 1: decoder consumes the head
- `Redirect` in 1: branch/jump taken; one-cycle pulse
- `RedirectPC` in ADDR_W: target PC

## Operation
- **Word-addressed PC.** Sequential next PC = `PCResult + 1`, modulo 2^ADDR_W (0xFFFF → 0x0000).
- **States:** RUN and DRAIN. Reset state is RUN.
- **Issue (RUN only):**
  - `MemReqValid = (outstanding + count < DEPTH) && !Redirect`.
  - On a `MemReqValid && MemReqReady` handshake: `PCWrite=1`, `PCNext=PCResult+1`, `PCResult` pushed into the tag FIFO, outstanding incremented.
- **Response:**
  - When `discard > 0`: the response is dropped and `discard` is decremented.
  - Otherwise: tag FIFO popped; {data, tag} written to the instruction queue; outstanding decremented.
- **Pop:** `InstValid && InstReady` removes the queue head.
- **Redirect (highest priority in any state):**
  - `PCWrite=1`, `PCNext=RedirectPC`.
  - Instruction queue and tag FIFO flushed.
  - `discard` = outstanding remaining after this cycle's response.
  - outstanding ← 0.
  - Pop and issue are suppressed in that cycle.
  - Next state is DRAIN if `discard` is nonzero, else RUN.
- **DRAIN:** no issue. Move to RUN in the cycle after `discard` reaches 0.
- **Simultaneous events:**
  - Redirect + response in the same cycle: the response is stale and discarded.
  - A Redirect received during DRAIN reloads PCNext; `discard` is unchanged.
- **PCWrite / PCNext outside handshake or Redirect:** `PCWrite=0`, `PCNext=PCResult`.
- **Reset values:**
  - Queue and tag FIFO empty; outstanding=0; discard=0; state RUN.
  - `InstValid=0`, `MemReqValid=0` during the Reset cycle, `PCWrite=0`.
  - `InstData=0`, `InstPC=0`.
- **Counter width:** outstanding and discard are $clog2(DEPTH)+1 bits; they never exceed DEPTH.

## Timing
- Request-to-PC: the PC advances at the edge ending the handshake cycle, so the next request is at PC+1 in the following cycle. Peak rate is one request per cycle.
- Response-to-`InstValid`: 1 cycle through the queue, 0 cycles with bypass.
- Redirect-to-first new request:
  - 1 cycle when nothing is in flight.
  - Otherwise 1 cycle after the last stale response.
- Queue full (`count = DEPTH`): issue stops. Credit accounting guarantees responses never overflow the queue.
- Queue empty: `InstValid=0`, and `InstData`/`InstPC` hold their last value.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - Applies when the queue is empty, the response is non-discarded and `InstReady=1`.
  - `InstValid=1`, `InstData=MemRespData`, `InstPC` = tag FIFO head, all in the same cycle.
  - No queue write.
- `FETCH_BYPASS_EN` undefined: every response goes through the queue, with a minimum 1-cycle latency.

## Structure
- **Shared package `fetch_pkg`:**
  - State enum `{RUN, DRAIN}`.
  - ADDR_W/DATA_W defaults.
  - Reset PC constant `16'h0000`.
- **Sub-module `fetch_fifo`:**
  - Parameterised width/depth synchronous FIFO with push, pop, flush, full, empty and count.
  - Instantiated twice: tag FIFO (ADDR_W) and instruction queue (ADDR_W+DATA_W).

## Test plan
- **Streaming from reset:** Reset for 2 cycles, PCResult driven from a PC model, memory with fixed 1-cycle latency and always ready.
  - Requests at 0x0000, 0x0001, 0x0002… one per cycle.
  - `InstPC` matches each address, `InstData` matches each word, in order.
- **Backpressure:** DEPTH=4, `InstReady=0`.
  - Exactly 4 handshakes, then `MemReqValid=0` and `PCWrite=0`; PC holds at 0x0004.
  - On `InstReady=1`, pops resume in order.
- **Redirect with 3 in flight:** memory latency 5, `Redirect=1`, `RedirectPC=0x0100`.
  - The 3 stale responses are dropped, none reaches `InstValid`.
  - The first new request is at 0x0100.
- **Redirect with response in the same cycle:** the response is discarded and the queue is empty the next cycle.
- **Wrap-around:** PC=0xFFFF is issued, then `PCNext=0x0000`; the next request is at 0x0000.
- **Bypass:** with `FETCH_BYPASS_EN` defined, empty queue and `InstReady=1`: `InstValid=1` in the response cycle with `InstData=MemRespData`. Without the macro it is one cycle later.
